// File: rtl/ex_branch_resolve_if.sv
// ID/EX-to-EX branch resolution bundle: decoded branch/jump operands in,
// registered resolution results out.
interface ex_branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             i_valid;
  logic             i_stall;
  logic             i_flush;
  logic             i_is_br;
  logic             i_is_jal;
  logic             i_is_jalr;
  logic [2:0]       i_funct3;
  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_rs1;
  logic [XLEN-1:0]  i_rs2;
  logic [XLEN-1:0]  i_imm;
  logic             i_pred_taken;
  logic             o_valid;
  logic             o_taken;
  logic [XLEN-1:0]  o_target;
  logic [XLEN-1:0]  o_link;
  logic             o_redirect;
  logic [XLEN-1:0]  o_redirect_pc;
  logic             o_illegal;
  logic [CNT_W-1:0] o_mispred_cnt;

  // Pipeline side feeding the stage and consuming its results.
  modport master (
    output i_valid, i_stall, i_flush, i_is_br, i_is_jal, i_is_jalr, i_funct3,
           i_pc, i_rs1, i_rs2, i_imm, i_pred_taken,
    input  o_valid, o_taken, o_target, o_link, o_redirect, o_redirect_pc,
           o_illegal, o_mispred_cnt
  );

  // The resolution stage itself.
  modport slave (
    input  i_valid, i_stall, i_flush, i_is_br, i_is_jal, i_is_jalr, i_funct3,
           i_pc, i_rs1, i_rs2, i_imm, i_pred_taken,
    output o_valid, o_taken, o_target, o_link, o_redirect, o_redirect_pc,
           o_illegal, o_mispred_cnt
  );
endinterface

// File: rtl/ex_branch_resolve.sv
// Execute-stage branch/jump resolution: evaluates the branch condition with a
// single subtractor, computes target/link, checks the prediction and issues a
// one-pulse redirect per mispredicted instruction. One registered stage.
module ex_branch_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  ex_branch_resolve_if.slave bus
);

  logic [XLEN:0]    c_diff;
  logic             c_eq;
  logic             c_ltu;
  logic             c_lt;
  logic             c_ctrl;
  logic             c_taken;
  logic             c_illegal;
  logic [XLEN-1:0]  c_target;
  logic [XLEN-1:0]  c_jalr_sum;
  logic [XLEN-1:0]  c_link;
  logic             c_accept;
  logic             c_mis;
  logic             c_redirect;

  logic             r_valid;
  logic             r_taken;
  logic [XLEN-1:0]  r_target;
  logic [XLEN-1:0]  r_link;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_illegal;
  logic             r_mis;
  logic             r_sent;
  logic [CNT_W-1:0] r_cnt;

  // Resolve condition, target, link and mispredict for the incoming instruction.
  always_comb begin
    c_diff     = {1'b0, bus.i_rs1} + {1'b0, ~bus.i_rs2} + {{XLEN{1'b0}}, 1'b1};
    // rs1 - rs2 is zero exactly when the operands are equal
    c_eq       = (c_diff[XLEN-1:0] == '0);
    c_ltu      = ~c_diff[XLEN];
    c_lt       = (bus.i_rs1[XLEN-1] != bus.i_rs2[XLEN-1]) ? bus.i_rs1[XLEN-1] : c_ltu;
    c_ctrl     = bus.i_is_br | bus.i_is_jal | bus.i_is_jalr;
    c_link     = bus.i_pc + XLEN'(4);
    c_jalr_sum = bus.i_rs1 + bus.i_imm;
    c_taken    = 1'b0;
    c_illegal  = 1'b0;
    c_target   = bus.i_pc + bus.i_imm;
    if (bus.i_is_jalr) begin
      c_taken  = 1'b1;
      c_target = c_jalr_sum & ~XLEN'(1);
    end else if (bus.i_is_jal) begin
      c_taken  = 1'b1;
    end else if (bus.i_is_br) begin
      case (bus.i_funct3)
        3'b000:  c_taken = c_eq;
        3'b001:  c_taken = ~c_eq;
        3'b100:  c_taken = c_lt;
        3'b101:  c_taken = ~c_lt;
        3'b110:  c_taken = c_ltu;
        3'b111:  c_taken = ~c_ltu;
        default: c_illegal = 1'b1;
      endcase
    end
    c_accept   = bus.i_valid & ~bus.i_stall & ~bus.i_flush;
    // plain instructions never mispredict, whatever the front end guessed
    c_mis      = c_accept & c_ctrl & (c_taken != bus.i_pred_taken);
    c_redirect = r_mis & r_valid & ~r_sent;
  end

  // Stage register: reset > flush > stall > load; redirect sent-flag and counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid       <= 1'b0;
      r_taken       <= 1'b0;
      r_target      <= '0;
      r_link        <= '0;
      r_redirect_pc <= '0;
      r_illegal     <= 1'b0;
      r_mis         <= 1'b0;
      r_sent        <= 1'b0;
      r_cnt         <= '0;
    end else if (bus.i_flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_mis     <= 1'b0;
      r_sent    <= 1'b0;
    end else if (bus.i_stall) begin
      if (c_redirect) r_sent <= 1'b1;
    end else begin
      r_valid       <= bus.i_valid;
      r_taken       <= c_taken;
      r_target      <= c_target;
      r_link        <= c_link;
      r_redirect_pc <= c_taken ? c_target : c_link;
      r_illegal     <= bus.i_valid & c_illegal;
      r_mis         <= c_mis;
      r_sent        <= 1'b0;
      if (c_mis && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.o_valid       = r_valid;
  assign bus.o_taken       = r_taken;
  assign bus.o_target      = r_target;
  assign bus.o_link        = r_link;
  assign bus.o_redirect    = c_redirect;
  assign bus.o_redirect_pc = r_redirect_pc;
  assign bus.o_illegal     = r_illegal;
  assign bus.o_mispred_cnt = r_cnt;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Bench for ex_branch_resolve: directed cases plus randomized traffic checked
// against a behavioural model; a second instance with a 2-bit counter covers
// saturation.
module tb_ex_branch_resolve;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_branch_resolve_if #(.XLEN(32), .CNT_W(32)) bus0 ();
  ex_branch_resolve_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  ex_branch_resolve #(.XLEN(32), .CNT_W(32)) dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
  ex_branch_resolve #(.XLEN(32), .CNT_W(2))  dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

  assign bus2.i_valid      = bus0.i_valid;
  assign bus2.i_stall      = bus0.i_stall;
  assign bus2.i_flush      = bus0.i_flush;
  assign bus2.i_is_br      = bus0.i_is_br;
  assign bus2.i_is_jal     = bus0.i_is_jal;
  assign bus2.i_is_jalr    = bus0.i_is_jalr;
  assign bus2.i_funct3     = bus0.i_funct3;
  assign bus2.i_pc         = bus0.i_pc;
  assign bus2.i_rs1        = bus0.i_rs1;
  assign bus2.i_rs2        = bus0.i_rs2;
  assign bus2.i_imm        = bus0.i_imm;
  assign bus2.i_pred_taken = bus0.i_pred_taken;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // behavioural model of what the stage should be presenting
  bit          m_valid, m_taken, m_illegal, m_mis, m_sent, m_data_ok;
  logic [31:0] m_target, m_link, m_rpc, m_cnt;
  logic [1:0]  m_cnt2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pulse();
    return m_valid && m_mis && !m_sent;
  endfunction

  // Architectural effect of one clock edge given the inputs currently applied.
  task automatic model_update();
    bit          pulse, taken, ill, ctrl, mis;
    logic [31:0] tgt, pc4;
    pulse = exp_pulse();
    if (rst) begin
      m_valid = 0; m_taken = 0; m_illegal = 0; m_mis = 0; m_sent = 0;
      m_target = 0; m_link = 0; m_rpc = 0; m_cnt = 0; m_cnt2 = 0; m_data_ok = 1;
    end else if (bus0.i_flush) begin
      m_valid = 0; m_illegal = 0; m_mis = 0; m_sent = 0; m_data_ok = 0;
    end else if (bus0.i_stall) begin
      if (pulse) m_sent = 1;
    end else begin
      taken = 0; ill = 0;
      pc4   = bus0.i_pc + 32'd4;
      tgt   = bus0.i_pc + bus0.i_imm;
      ctrl  = bus0.i_is_br || bus0.i_is_jal || bus0.i_is_jalr;
      if (bus0.i_is_jalr) begin
        taken = 1;
        tgt   = (bus0.i_rs1 + bus0.i_imm) & 32'hFFFF_FFFE;
      end else if (bus0.i_is_jal) begin
        taken = 1;
      end else if (bus0.i_is_br) begin
        case (bus0.i_funct3)
          3'd0: taken = (bus0.i_rs1 == bus0.i_rs2);
          3'd1: taken = (bus0.i_rs1 != bus0.i_rs2);
          3'd4: taken = ($signed(bus0.i_rs1) <  $signed(bus0.i_rs2));
          3'd5: taken = ($signed(bus0.i_rs1) >= $signed(bus0.i_rs2));
          3'd6: taken = (bus0.i_rs1 <  bus0.i_rs2);
          3'd7: taken = (bus0.i_rs1 >= bus0.i_rs2);
          default: ill = 1;
        endcase
      end
      mis       = bus0.i_valid && ctrl && (taken != bus0.i_pred_taken);
      m_valid   = bus0.i_valid;
      m_taken   = taken;
      m_target  = tgt;
      m_link    = pc4;
      m_rpc     = taken ? tgt : pc4;
      m_illegal = bus0.i_valid && ill;
      m_mis     = mis;
      m_sent    = 0;
      m_data_ok = bus0.i_valid;
      if (mis) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
    end
  endtask

  task automatic check_all();
    check("valid",    {31'd0, bus0.o_valid},    {31'd0, m_valid});
    check("redirect", {31'd0, bus0.o_redirect}, {31'd0, exp_pulse()});
    check("illegal",  {31'd0, bus0.o_illegal},  {31'd0, m_illegal});
    check("cnt",      bus0.o_mispred_cnt,       m_cnt);
    check("cnt2",     {30'd0, bus2.o_mispred_cnt}, {30'd0, m_cnt2});
    if (m_valid || m_data_ok) begin
      check("taken",  {31'd0, bus0.o_taken}, {31'd0, m_taken});
      check("target", bus0.o_target,         m_target);
      check("link",   bus0.o_link,           m_link);
      check("rpc",    bus0.o_redirect_pc,    m_rpc);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit r, input bit v, input bit s, input bit f,
                       input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input bit pred);
    rst = r;
    bus0.i_valid = v; bus0.i_stall = s; bus0.i_flush = f;
    bus0.i_is_br = br; bus0.i_is_jal = jal; bus0.i_is_jalr = jalr;
    bus0.i_funct3 = f3; bus0.i_pc = pc; bus0.i_rs1 = a; bus0.i_rs2 = b;
    bus0.i_imm = imm; bus0.i_pred_taken = pred;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    cycle();
    cycle();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'(32'($urandom_range(0, 3)));
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int unsigned n_red, n_val;
    logic [31:0] a;
    m_valid = 0; m_taken = 0; m_illegal = 0; m_mis = 0; m_sent = 0; m_data_ok = 0;
    m_target = 0; m_link = 0; m_rpc = 0; m_cnt = 0; m_cnt2 = 0;
    do_reset();
    check("reset_target", bus0.o_target, 32'd0);
    check("reset_cnt",    bus0.o_mispred_cnt, 32'd0);

    // BLTU 1 < 0xFFFFFFFF, predicted not taken
    drive(0, 1, 0, 0, 1, 0, 0, 3'd6, 32'h100, 32'h1, 32'hFFFF_FFFF, 32'h20, 0);
    cycle();
    check("bltu_taken", {31'd0, bus0.o_taken}, 32'd1);
    check("bltu_redir", {31'd0, bus0.o_redirect}, 32'd1);
    check("bltu_rpc",   bus0.o_redirect_pc, 32'h120);
    check("bltu_cnt",   bus0.o_mispred_cnt, 32'd1);

    // BLT same operands: 1 < -1 is false
    drive(0, 1, 0, 0, 1, 0, 0, 3'd4, 32'h100, 32'h1, 32'hFFFF_FFFF, 32'h20, 0);
    cycle();
    check("blt_taken", {31'd0, bus0.o_taken}, 32'd0);
    check("blt_redir", {31'd0, bus0.o_redirect}, 32'd0);
    drive(0, 1, 0, 0, 1, 0, 0, 3'd4, 32'h100, 32'h1, 32'hFFFF_FFFF, 32'h20, 1);
    cycle();
    check("blt_p1_redir", {31'd0, bus0.o_redirect}, 32'd1);
    check("blt_p1_rpc",   bus0.o_redirect_pc, 32'h104);

    // JALR clears bit 0 of the sum
    drive(0, 1, 0, 0, 0, 0, 1, 3'd0, 32'h200, 32'h1001, 32'h0, 32'h4, 1);
    cycle();
    check("jalr_target", bus0.o_target, 32'h1004);
    check("jalr_link",   bus0.o_link,   32'h204);
    check("jalr_taken",  {31'd0, bus0.o_taken}, 32'd1);

    // Mispredicted BEQ held by three stall cycles: one pulse only
    drive(0, 1, 0, 0, 1, 0, 0, 3'd0, 32'h300, 32'd5, 32'd5, 32'h40, 0);
    cycle();
    n_red = bus0.o_redirect; n_val = bus0.o_valid;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 1, 0, 0, 3'd0, 32'h400, 32'd1, 32'd1, 32'h8, 0);
      cycle();
      n_red += bus0.o_redirect; n_val += bus0.o_valid;
    end
    check("stall_pulses", n_red, 32'd1);
    check("stall_valid",  n_val, 32'd4);
    check("stall_cnt",    bus0.o_mispred_cnt, 32'd3);

    // valid together with flush: dropped, counter untouched
    drive(0, 1, 0, 1, 1, 0, 0, 3'd0, 32'h500, 32'd7, 32'd7, 32'h8, 0);
    cycle();
    check("flush_valid", {31'd0, bus0.o_valid}, 32'd0);
    check("flush_cnt",   bus0.o_mispred_cnt, 32'd3);

    // Reset in the middle of a stalled mispredict
    drive(0, 1, 0, 0, 0, 1, 0, 3'd0, 32'h600, 32'd0, 32'd0, 32'h10, 0);
    cycle();
    drive(1, 1, 1, 0, 0, 1, 0, 3'd0, 32'h600, 32'd0, 32'd0, 32'h10, 0);
    cycle();
    check("rst_mid_valid", {31'd0, bus0.o_valid}, 32'd0);
    check("rst_mid_redir", {31'd0, bus0.o_redirect}, 32'd0);
    check("rst_mid_cnt",   bus0.o_mispred_cnt, 32'd0);
    check("rst_mid_link",  bus0.o_link, 32'd0);

    // funct3 = 010 is illegal and not taken
    drive(0, 1, 0, 0, 1, 0, 0, 3'd2, 32'h700, 32'd0, 32'd0, 32'h10, 0);
    cycle();
    check("ill_flag",  {31'd0, bus0.o_illegal}, 32'd1);
    check("ill_taken", {31'd0, bus0.o_taken},   32'd0);

    // Five back-to-back mispredicts saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 1, 0, 3'd0, 32'h800 + 32'(i * 4), 32'd0, 32'd0, 32'h10, 0);
      cycle();
      check("b2b_pulse", {31'd0, bus0.o_redirect}, 32'd1);
    end
    check("sat_cnt2", {30'd0, bus2.o_mispred_cnt}, 32'd3);
    check("sat_cnt",  bus0.o_mispred_cnt, 32'd5);

    // PC wraparound
    drive(0, 1, 0, 0, 0, 1, 0, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1);
    cycle();
    check("wrap_target", bus0.o_target, 32'h4);
    check("wrap_link",   bus0.o_link,   32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      a = rand_operand();
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 12) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            3'($urandom_range(0, 7)),
            $urandom, a,
            ($urandom_range(0, 3) == 0) ? a : rand_operand(),
            $urandom, $urandom_range(0, 1) == 1);
      cycle();
    end

    idle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
